// File: rtl/ssd_pkg.sv
// ssd_pkg: active-low seven-segment glyph constants and lookup (bit0 = a).
// Shared by every display block that needs nibble-to-segment decoding.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Nibbles above 9 render as blanks unless hex glyphs are enabled.
  function automatic logic [6:0] glyph(
    input logic [3:0] nib,
    input logic       hex_mode
  );
    logic [6:0] g;
    unique case (nib)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      4'hF: g = GLYPH_F;
    endcase
    if ((nib > 4'h9) && !hex_mode) begin
      g = SEG_BLANK;
    end
    return g;
  endfunction

endpackage

// File: rtl/ssd_glyph_lut.sv
// ssd_glyph_lut: combinational nibble + hex_mode to active-low segments.
// Thin wrapper over ssd_pkg::glyph so other display blocks can reuse it.
module ssd_glyph_lut
  import ssd_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       hex_mode,
  output logic [6:0] seg
);

  assign seg = glyph(nib, hex_mode);

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: multiplexed common-anode 7-seg scanner with anode guard.
// Optional decimal point ports are enabled by defining SSD_DP_EN.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
`ifdef SSD_DP_EN
  ,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp
`endif
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST =
    CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_nxt;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idx_nxt;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [3:0]              nib;
  logic                    nib_lz;
  logic [6:0]              lut_seg;
  logic [6:0]              seg_nxt;
  logic                    terminal;
  logic                    in_guard;

  assign terminal = (cnt == CNT_LAST);
  assign cnt_nxt  = terminal ? '0 : cnt + CW'(1);

  always_comb begin
    idx_nxt = idx;
    if (terminal) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  // Digit k is a leading zero when nibble k and every nibble above it is 0.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero & (shadow[4*k +: 4] == 4'h0);
      if (k != 0) begin
        lz_mask[k] = upper_zero;
      end
    end
  end

  always_comb begin
    nib    = 4'h0;
    nib_lz = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IW'(k)) begin
        nib    = shadow[4*k +: 4];
        nib_lz = lz_mask[k];
      end
    end
  end

  ssd_glyph_lut u_lut (
    .nib      (nib),
    .hex_mode (hex_mode),
    .seg      (lut_seg)
  );

  assign seg_nxt =
    (lz_blank && nib_lz) ? SEG_BLANK : lut_seg;

  assign in_guard =
    (GUARD_CYCLES > 0) &&
    (int'(cnt_nxt) < GUARD_CYCLES);

  always_comb begin
    an_nxt = '1;
    if (!in_guard) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_nxt[k] = (idx_nxt != IW'(k));
      end
    end
  end

  // seg only changes on the slot boundary, so mode inputs never glitch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      seg    <= SEG_BLANK;
      an     <= '1;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      an  <= an_nxt;
      if (load) begin
        shadow <= value;
      end
      if (terminal) begin
        seg <= seg_nxt;
      end
    end
  end

`ifdef SSD_DP_EN
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic                  dp_nxt;

  always_comb begin
    dp_nxt = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IW'(k)) begin
        dp_nxt = ~shadow_dp[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_dp <= '0;
      dp        <= 1'b1;
    end else begin
      if (load) begin
        shadow_dp <= dp_in;
      end
      if (terminal) begin
        dp <= dp_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: slot-level model plus directed literal checks.
// Define SSD_DP_EN to also exercise the decimal point path.
module tb_ssd_scan_driver;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int G  = 1;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic [15:0]   value;
  logic          hex_mode;
  logic          lz_blank;
  logic [6:0]    seg;
  logic [3:0]    an;
  logic [3:0]    dp_in;
`ifdef SSD_DP_EN
  logic          dp;
`endif

  int checks   = 0;
  int failures = 0;

  ssd_scan_driver #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (G)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .hex_mode (hex_mode),
    .lz_blank (lz_blank),
    .seg      (seg),
    .an       (an)
`ifdef SSD_DP_EN
    ,
    .dp_in    (dp_in),
    .dp       (dp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] tbl [16];
  initial tbl = '{7'h40, 7'h79, 7'h24, 7'h30,
                  7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03,
                  7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: t counts clock edges since reset release.
  int         t;
  logic [15:0] sh;
  logic [3:0]  shd;
  logic [6:0]  seg_m;
  logic        dp_m;

  function automatic logic [6:0] exp_seg(
    logic [15:0] s, int d, logic hx, logic lz);
    logic [15:0] up;
    logic [3:0]  n;
    up = s >> (4 * d);
    n  = up[3:0];
    if (lz && d != 0 && up == 16'h0) return 7'h7F;
    if (n > 4'd9 && !hx) return 7'h7F;
    return tbl[n];
  endfunction

  function automatic logic [3:0] an_exp(int tt);
    logic [3:0] one;
    one = 4'b0001;
    if (tt == 0 || (tt % RD) < G) return 4'hF;
    return ~(one << ((tt / RD) % N));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t     <= 0;
      sh    <= '0;
      shd   <= '0;
      seg_m <= 7'h7F;
      dp_m  <= 1'b1;
    end else begin
      if (t % RD == RD - 1) begin
        seg_m <= exp_seg(sh, (t / RD + 1) % N,
                         hex_mode, lz_blank);
        dp_m  <= ~shd[(t / RD + 1) % N];
      end
      if (load) begin
        sh  <= value;
        shd <= dp_in;
      end
      t <= t + 1;
    end
  end

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h expected=%h",
               name, t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("seg_cycle", 32'(seg), 32'(seg_m));
    chk("an_cycle", 32'(an), 32'(an_exp(t)));
`ifdef SSD_DP_EN
    chk("dp_cycle", 32'(dp), 32'(dp_m));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go(int slot, int cyc);
    int n;
    n = 0;
    while (t != slot * RD + cyc && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("goto_timeout", t, slot * RD + cyc);
  endtask

  task automatic lit(string name, logic [6:0] s,
                     logic [3:0] a);
    chk({name, "_seg"}, 32'(seg), 32'(s));
    chk({name, "_an"}, 32'(an), 32'(a));
  endtask

  task automatic do_load(logic [15:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    load     = 1'b0;
    value    = '0;
    hex_mode = 1'b0;
    lz_blank = 1'b0;
    dp_in    = 4'b0010;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    lit("rel_t0", 7'h7F, 4'hF);
    tick();
    lit("rel_t1", 7'h7F, 4'hE);

    do_load(16'h1234);
    go(1, 3); lit("d1_1234", 7'h30, 4'hD);
`ifdef SSD_DP_EN
    chk("dp_slot1", 32'(dp), 32'(0));
`endif
    go(2, 0); chk("guard_an", 32'(an), 32'hF);
    go(2, 3); lit("d2_1234", 7'h24, 4'hB);
`ifdef SSD_DP_EN
    chk("dp_slot2", 32'(dp), 32'(1));
`endif
    go(3, 3); lit("d3_1234", 7'h79, 4'h7);
    go(4, 3); lit("d0_1234", 7'h19, 4'hE);

    rst_n = 1'b0;
    #1;
    lit("mid_rst", 7'h7F, 4'hF);
`ifdef SSD_DP_EN
    chk("dp_rst", 32'(dp), 32'(1));
`endif
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    lit("rel2_t0", 7'h7F, 4'hF);
    tick();
    lit("rel2_t1", 7'h7F, 4'hE);
    go(0, 5); lit("rel2_t5", 7'h7F, 4'hE);

    do_load(16'h00A5);
    go(1, 3); lit("a5_dec_d1", 7'h7F, 4'hD);
    hex_mode = 1'b1;
    go(1, 6); lit("no_glitch", 7'h7F, 4'hD);
    go(4, 3); lit("a5_hex_d0", 7'h12, 4'hE);
    go(5, 3); lit("a5_hex_d1", 7'h08, 4'hD);

    lz_blank = 1'b1;
    do_load(16'h0070);
    go(6, 3); lit("lz70_d2", 7'h7F, 4'hB);
    go(7, 3); lit("lz70_d3", 7'h7F, 4'h7);
    go(8, 3); lit("lz70_d0", 7'h40, 4'hE);
    go(9, 3); lit("lz70_d1", 7'h78, 4'hD);
    do_load(16'h0000);
    go(10, 3); lit("lz0_d2", 7'h7F, 4'hB);
    go(11, 3); lit("lz0_d3", 7'h7F, 4'h7);
    go(12, 3); lit("lz0_d0", 7'h40, 4'hE);
    go(13, 3); lit("lz0_d1", 7'h7F, 4'hD);

    lz_blank = 1'b0;
    go(13, 7);
    do_load(16'hFFFF);
    go(14, 3); lit("term_old", 7'h40, 4'hB);
    go(15, 3); lit("term_new", 7'h0E, 4'h7);
    go(16, 3); lit("term_d0", 7'h0E, 4'hE);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
